sync_updown_counter: RTL
========================

// Module: sync_updown_counter
// PURPOSE
//  Parametrised synchronous up/down modulo counter: enable, direction control, parallel load,
//  prescaled stepping, registered terminal-count pulse. Successor to the fixed 4-bit up counter;
//  general-purpose event/timebase counter for the sequential-circuit library.
// PARAMETERS
//  WIDTH     4    counter width in bits (>=1)
//  MODULUS   16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  PRESCALE  1    enabled cycles per count step; 1 = step every enabled cycle (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      reset, asynchronous, active-low
//  en        in   1      count enable (qualifies prescaler and step)
//  up_dn     in   1      1 = count up, 0 = count down; sampled each step
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value loaded when load=1
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, 1 cycle
//  load_err  out  1      pulse: load_val >= MODULUS was clamped
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n). rst_n=0: count=0, tc=0,
//    load_err=0, prescaler=0 immediately; reset mid-count discards all state, no pending tc.
//  - Priority per edge: reset > load > step. en ignored in load cycle.
//  - load=1: count<=load_val (or MODULUS-1 if load_val>=MODULUS, load_err<=1 that cycle);
//    prescaler cleared; tc<=0. Visible next cycle (latency 1).
//  - Prescaler: counts enabled cycles 0..PRESCALE-1; step occurs on the enabled cycle where
//    prescaler==PRESCALE-1, prescaler then returns to 0. en=0 freezes prescaler and count.
//  - Step up: count==MODULUS-1 -> 0 and tc<=1; else count+1. Step down: count==0 ->
//    MODULUS-1 and tc<=1; else count-1. tc high exactly the cycle after the wrapping edge,
//    coincident with new count value; otherwise 0.
//  - Direction change mid-run takes effect on next step; no skipped or repeated values.
//  - Arithmetic in WIDTH bits; MODULUS==2**WIDTH wraps naturally, compare still explicit.
//  - load_err and tc are 0 in every cycle not described above.
// CONFIGURATION
//  COUNTER_SAT_EN defined: saturating mode. Up step at MODULUS-1 holds MODULUS-1; down step
//    at 0 holds 0; tc still pulses for each step attempted at the boundary.
//  COUNTER_SAT_EN undefined: modulo wrap as in BEHAVIOUR.
// STRUCTURE
//  - Package cnt_pkg: direction constants CNT_DN=1'b0, CNT_UP=1'b1; function clog2 for
//    prescaler width; parameter-legality checks helper.
//  - Sub-module cnt_prescaler (PRESCALE param; in clk, rst_n, en, clr; out step): generates
//    one-cycle step strobe; PRESCALE==1 degenerates to step=en.
//  - Top holds count register, boundary compare, load clamp, tc/load_err registers.
//  - Elaboration-time error if MODULUS > 2**WIDTH or MODULUS < 2 or PRESCALE < 1.
// TESTING (WIDTH=4, MODULUS=10, PRESCALE=1 unless noted; 10 ns clock)
//  1. rst_n low then release, en=1, up_dn=1 for 12 cycles -> count 0..9,0,1; tc=1 only
//     with count==0 after 9; rst_n pulsed low mid-count -> count=0 asynchronously, tc=0.
//  2. load_val=3, load, then up_dn=0, en=1 -> 3,2,1,0,9,8; tc=1 with the 9.
//  3. load_val=12 -> count=9, load_err=1 for one cycle; load with en=1 same cycle -> no step.
//  4. PRESCALE=3, en=1 up -> count increments every 3rd cycle; en low 2 cycles mid-period
//     -> step delayed by exactly 2 cycles; load clears prescaler phase.
//  5. COUNTER_SAT_EN: up from 7 for 5 steps -> 8,9,9,9,9, tc=1 on each of the held 9 steps;
//     down from 1 -> 0,0 with tc on the hold.
//  6. Toggle up_dn every step from 5 -> 6,5,6,5; no tc; MODULUS=16 WIDTH=4 wrap 15->0 tc=1.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and elaboration helpers for sync_updown_counter
//   CNT_DN / CNT_UP : encodings of the up_dn input
//   clog2           : bits needed to hold 0..v-1 (minimum 1)
//   params_ok       : legality of WIDTH / MODULUS / PRESCALE
package cnt_pkg;
  localparam logic CNT_DN = 1'b0;
  localparam logic CNT_UP = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic bit params_ok(input int w, input int m, input int p);
    return w >= 1 && m >= 2 && (w >= 31 || m <= (1 << w)) && p >= 1;
  endfunction
endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: one-cycle step strobe every PRESCALE enabled cycles
//   clk, rst_n : clock, async active-low reset
//   en         : counts an enabled cycle
//   clr        : returns the phase to 0 and suppresses the strobe
//   step       : high on the enabled cycle that completes a period
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);
  if (PRESCALE == 1) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign step = en && !clr;
  end else begin : g_div
    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_q, pre_d;
    always_comb pre_d = clr ? '0 : !en ? pre_q : (pre_q == LAST) ? '0 : pre_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pre_q <= '0;
      else pre_q <= pre_d;
    assign step = en && !clr && pre_q == LAST;
  end
endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: prescaled up/down modulo counter with load and terminal-count pulse
//   clk, rst_n : clock, async active-low reset
//   en, up_dn  : count enable, direction (CNT_UP / CNT_DN)
//   load       : synchronous load of load_val (clamped to MODULUS-1)
//   count      : registered count
//   tc         : one-cycle pulse with the value produced by a boundary step
//   load_err   : one-cycle pulse when a load was clamped
//   Define COUNTER_SAT_EN to hold at the boundary instead of wrapping.
module sync_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             load_err
);
  if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
    $error("sync_updown_counter: illegal WIDTH/MODULUS/PRESCALE");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] count_q, count_d, wrap_val;
  logic tc_q, tc_d, load_err_q, load_err_d;
  logic step, at_bound, over;
  cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en && !load),
    .clr  (load),
    .step (step)
  );
  // widened so MODULUS == 2**WIDTH never flags
  assign over = {1'b0, load_val} > {1'b0, MAX};
  assign at_bound = (up_dn == CNT_UP) ? count_q == MAX : count_q == '0;
`ifdef COUNTER_SAT_EN
  assign wrap_val = count_q;
`else
  assign wrap_val = (up_dn == CNT_UP) ? '0 : MAX;
`endif
  always_comb begin
    count_d = load ? (over ? MAX : load_val) :
              !step ? count_q :
              at_bound ? wrap_val :
              (up_dn == CNT_UP) ? count_q + 1'b1 : count_q - 1'b1;
    tc_d = !load && step && at_bound;
    load_err_d = load && over;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;
endmodule
